// File: rtl/pair_tracker_pkg.sv
// Shared types and default parameters for the pair_tracker block.
package pair_tracker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_SAT  = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    EC_NONE = 2'd0,
    EC_INV  = 2'd1,
    EC_JUMP = 2'd2
  } err_code_t;

  typedef enum logic [1:0] {
    CLS_ADV  = 2'd0,
    CLS_HOLD = 2'd1,
    CLS_JUMP = 2'd2
  } step_cls_t;

  localparam int DEF_WIDTH      = 11;
  localparam int DEF_HOLD_LIMIT = 4;
  localparam int DEF_STEP       = 2;

endpackage

// File: rtl/pair_step_cmp.sv
// Combinational classifier: compares (x,y) against the previous sample and
// checks the x - y == 1 invariant, all modulo 2^WIDTH.
module pair_step_cmp
  import pair_tracker_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int STEP  = DEF_STEP
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] px,
  input  logic [WIDTH-1:0] py,
  output step_cls_t        cls,
  output logic             inv_bad
);

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] ONE_W  = WIDTH'(1);

  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] px_adv;
  logic [WIDTH-1:0] py_adv;

  always_comb begin
    diff    = x - y;
    px_adv  = px + STEP_W;
    py_adv  = py + STEP_W;
    inv_bad = (diff != ONE_W);
    cls     = CLS_JUMP;
    if (x == px_adv && y == py_adv) begin
      cls = CLS_ADV;
    end else if (x == px && y == py) begin
      cls = CLS_HOLD;
    end
  end

endmodule

// File: rtl/pair_tracker.sv
// Tracks a pair of lock-stepped upstream counters, flags invariant/step errors
// and stall saturation. Define PAIR_TRACKER_SVA_EN to compile in assertions.
//
// state | meaning
// IDLE  | waiting for first sample to load px/py
// RUN   | counters advancing; counting consecutive holds
// SAT   | HOLD_LIMIT consecutive holds seen; only holds allowed
// ERR   | sticky error until rst
module pair_tracker
  import pair_tracker_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int HOLD_LIMIT = DEF_HOLD_LIMIT,
  parameter int STEP       = DEF_STEP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [1:0]       state,
  output logic [7:0]       step_cnt,
  output logic             saturated,
  output logic             err,
  output logic [1:0]       err_code
);

  localparam logic [3:0] HOLD_LIM_W = 4'(HOLD_LIMIT);

  state_t           st, st_nxt;
  err_code_t        code_q, code_nxt;
  logic [7:0]       step_nxt;
  logic [3:0]       hold_cnt, hold_nxt;
  logic [WIDTH-1:0] px, py, px_nxt, py_nxt;
  step_cls_t        cls;
  logic             inv_bad;

  pair_step_cmp #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_cmp (
    .x       (x),
    .y       (y),
    .px      (px),
    .py      (py),
    .cls     (cls),
    .inv_bad (inv_bad)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= ST_IDLE;
      code_q    <= EC_NONE;
      step_cnt  <= 8'd0;
      hold_cnt  <= 4'd0;
      px        <= '0;
      py        <= '0;
      saturated <= 1'b0;
      err       <= 1'b0;
    end else begin
      st        <= st_nxt;
      code_q    <= code_nxt;
      step_cnt  <= step_nxt;
      hold_cnt  <= hold_nxt;
      px        <= px_nxt;
      py        <= py_nxt;
      saturated <= (st_nxt == ST_SAT);
      err       <= (st_nxt == ST_ERR);
    end
  end

  always_comb begin
    st_nxt   = st;
    code_nxt = code_q;
    step_nxt = step_cnt;
    hold_nxt = hold_cnt;
    px_nxt   = px;
    py_nxt   = py;
    if (en && st != ST_ERR) begin
      px_nxt = x;
      py_nxt = y;
      // invariant breach always wins over the step classification
      if (inv_bad) begin
        st_nxt   = ST_ERR;
        code_nxt = EC_INV;
      end else begin
        case (st)
          ST_IDLE: st_nxt = ST_RUN;
          ST_RUN: begin
            case (cls)
              CLS_ADV: begin
                if (step_cnt != 8'hFF) step_nxt = step_cnt + 8'd1;
                hold_nxt = 4'd0;
              end
              CLS_HOLD: begin
                hold_nxt = hold_cnt + 4'd1;
                if (hold_nxt == HOLD_LIM_W) st_nxt = ST_SAT;
              end
              default: begin
                st_nxt   = ST_ERR;
                code_nxt = EC_JUMP;
              end
            endcase
          end
          ST_SAT: begin
            if (cls != CLS_HOLD) begin
              st_nxt   = ST_ERR;
              code_nxt = EC_JUMP;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign state    = st;
  assign err_code = code_q;

`ifdef PAIR_TRACKER_SVA_EN
  a_err_sticky: assert property (@(posedge clk) (err && !rst) |=> err);
  a_step_mono:  assert property (@(posedge clk) !rst |=> (step_cnt >= $past(step_cnt)));
  a_sat_hold:   assert property (@(posedge clk) saturated |-> (hold_cnt == HOLD_LIM_W));
  a_err_state:  assert property (@(posedge clk) (st == ST_ERR && !rst) |=> (st == ST_ERR));
  a_code_err:   assert property (@(posedge clk) ((code_q != EC_NONE) == err));
`endif

endmodule

// File: doc/pair_tracker.md
PAIR_TRACKER -- requirements
Module: pair_tracker

Interface
REQ-001 Parameter WIDTH, default 11, width of the x/y operands.
REQ-002 Parameter HOLD_LIMIT, default 4, consecutive hold samples needed to declare saturation (legal range 2..15).
REQ-003 Parameter STEP, default 2, expected per-sample increment of both x and y.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 en  input  1  sample enable; x/y are consumed only on cycles with en=1.
REQ-007 x  input  WIDTH  upstream counter value x.
REQ-008 y  input  WIDTH  upstream counter value y.
REQ-009 state  output  2  current FSM state (IDLE=0, RUN=1, SAT=2, ERR=3).
REQ-010 step_cnt  output  8  number of accepted advance samples, saturating at 255.
REQ-011 saturated  output  1  high exactly while state==SAT.
REQ-012 err  output  1  high exactly while state==ERR.
REQ-013 err_code  output  2  NONE=0, INV=1 (invariant breach), JUMP=2 (illegal transition); valid while err=1, 0 otherwise.

Function
REQ-014 Invariant: a sample is INV-bad when (x - y) mod 2^WIDTH != 1.
REQ-015 Classification vs previous sample (px,py), all modulo 2^WIDTH: ADV if x==px+STEP and y==py+STEP; HOLD if x==px and y==py; otherwise JUMP.
REQ-016 IDLE: first en=1 sample loads px/py; goes to ERR/INV if INV-bad, else RUN; step_cnt unchanged.
REQ-017 RUN, en=1: INV-bad -> ERR/INV; else ADV -> step_cnt+1 (hold at 255), hold_cnt=0; HOLD -> hold_cnt+1; JUMP -> ERR/JUMP.
REQ-018 RUN -> SAT on the HOLD sample that makes hold_cnt equal HOLD_LIMIT.
REQ-019 SAT, en=1: HOLD keeps SAT; ADV or JUMP -> ERR/JUMP; INV-bad -> ERR/INV.
REQ-020 INV has priority over JUMP when both apply in one sample.
REQ-021 ERR is sticky: state, err, err_code hold until rst; later samples ignored.
REQ-022 px/py update on every en=1 sample in IDLE, RUN, SAT; never in ERR.
REQ-023 en=0: no state, counter or px/py change; hold_cnt not reset.
REQ-024 All outputs registered; a sample taken at edge n shows its effect from edge n (visible in cycle n+1), latency 1.
REQ-025 Wrap-around: px=2^WIDTH-2, x=0 with STEP=2 classifies as ADV.

Reset
REQ-026 rst=1 at a posedge: state=IDLE, step_cnt=0, hold_cnt=0, px=py=0, saturated=0, err=0, err_code=0.
REQ-027 rst dominates en and any state including ERR; reset mid-run discards history, next en sample reloads as in REQ-016.

Configuration
REQ-028 Macro PAIR_TRACKER_SVA_EN defined: embedded concurrent assertions compiled in: err never falls without rst; step_cnt never decreases without rst; saturated implies hold_cnt==HOLD_LIMIT; state never leaves ERR without rst; err_code!=0 iff err.
REQ-029 Macro undefined: no assertions; functional behaviour cycle-identical.

Structure
REQ-030 Package pair_tracker_pkg holds state enum, err_code enum, and default WIDTH/HOLD_LIMIT/STEP constants.
REQ-031 One combinational sub-module pair_step_cmp takes x, y, px, py and returns ADV/HOLD/JUMP plus INV-bad; the FSM, counters and registers stay in pair_tracker.

Verification
REQ-032 rst, then en=1 with (x,y)=(2,1),(4,3),(6,5) -> RUN, step_cnt=2, err=0.
REQ-033 After (198,197),(200,199) then four (200,199) holds -> saturated=1 in cycle after 4th hold, state=SAT, step_cnt unchanged.
REQ-034 In RUN feed (4,0) -> err=1, err_code=INV next cycle; then feed valid pairs -> stays ERR until rst.
REQ-035 In RUN from (10,9) feed (14,13) -> err_code=JUMP; from (10,9) feed (12,0) -> err_code=INV (priority).
REQ-036 WIDTH=11: (2046,2045) then (0,2047) -> ADV, no error; en=0 gaps between samples leave step_cnt and state unchanged.
REQ-037 Assert rst in SAT and in ERR -> next cycle all outputs 0/IDLE; run with and without PAIR_TRACKER_SVA_EN, outputs identical.
